alu_cmd_sequencer: RTL

- Upstream feeder stage for the 8-bit combinational ALU.
- Accepts commands over a valid/ready handshake and holds a 4-entry x 8-bit operand register file.
- Drives registered A/B/instruction into the ALU, captures F back into the register file, and returns the result over a valid/ready response channel.
- Gives the ALU a sequenced, backpressure-aware front end for the top-level datapath.

---
 rtl/alu_cmd_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Front end for an external 8-bit combinational ALU. Commands arrive over a
// valid/ready channel and operate on a small operand register file. EXEC
// commands present registered operands and an instruction to the ALU for one
// cycle, write the ALU result back to the register file, and return it over a
// valid/ready response channel. READ returns a register value the same way.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_op                     00=LOAD 01=EXEC 10=READ 11=NOP
//   cmd_fn, cmd_rd, cmd_ra,    ALU instruction, destination, sources,
//   cmd_rb, cmd_imm            LOAD immediate
//   alu_a, alu_b, alu_instr    registered ALU inputs (change only on EXEC accept)
//   alu_f                      ALU combinational result
//   rsp_valid / rsp_ready      response handshake
//   rsp_data                   EXEC result or READ value
//   op_count                   completed EXEC count, wraps at 8 bits
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int FN_W   = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [FN_W-1:0]   cmd_fn,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FN_W-1:0]   alu_instr,
  input  logic [DATA_W-1:0] alu_f,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [7:0]        op_count
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_EXEC = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   rf_d [NREG];
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [FN_W-1:0]     alu_instr_q, alu_instr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [7:0]          op_count_q, op_count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, handshake outputs and datapath next values.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_instr_d = alu_instr_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_LOAD: rf_d[cmd_rd] = cmd_imm;
            OP_EXEC: begin
              // Operands are snapshotted here, so rd aliasing ra/rb is harmless.
              alu_a_d     = rf_q[cmd_ra];
              alu_b_d     = rf_q[cmd_rb];
              alu_instr_d = cmd_fn;
              rd_d        = cmd_rd;
              state_d     = S_ISSUE;
            end
            OP_READ: begin
              rsp_data_d = rf_q[cmd_ra];
              state_d    = S_RESP;
            end
            default: ; // NOP: accepted, nothing changes
          endcase
        end
      end
      S_ISSUE: begin
        // ALU inputs have been stable for this whole cycle; capture F.
        rf_d[rd_q] = alu_f;
        rsp_data_d = alu_f;
        op_count_d = op_count_q + 8'd1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the register file is reset along with the other registers because
  // its cleared contents are architecturally visible through READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= '0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      rf_q        <= rf_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_instr_q <= alu_instr_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_instr = alu_instr_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;

endmodule
